vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_sync_delay.sv | 26 ++
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 VGA timing constants and shared coordinate helpers.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE  = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_VISIBLE  = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int PIPE_DELAY = 2;

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Compare in int so an end bound of 1024 still works with 10-bit coordinates.
    function automatic logic in_span(coord_t v, int lo, int hi);
        return int'(v) >= lo && int'(v) < hi;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register for sync signals; every stage resets to 1 (inactive).
module vga_sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    if (DEPTH < 1) begin : g_depth_check
        $error("vga_sync_delay: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] sr;
    logic [DEPTH:0]   nxt;

    assign nxt = {sr, d};
    assign q   = sr[DEPTH-1];

    always_ff @(posedge vga_clk) begin
        if (!reset_n) sr <= '1;
        else          sr <= nxt[DEPTH-1:0];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, registered DrawX/DrawY/blank bus, pipelined hs/vs,
// frame/line strobes and a frame counter.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_end,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    if (PIPE_DELAY < 0) begin : g_delay_check
        $error("vga_timing_gen: PIPE_DELAY must not be negative");
    end

    coord_t hc;
    coord_t vc;
    logic   last_x;
    logic   last_y;
    logic   hs_raw;
    logic   vs_raw;

    always_comb begin
        last_x = hc == H_LAST;
        last_y = vc == V_LAST;
        hs_raw = !in_span(hc, HS_START, HS_END);
        vs_raw = !in_span(vc, VS_START, VS_END);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_count <= '0;
        end else begin
            hc          <= last_x ? '0 : hc + 10'd1;
            vc          <= last_x ? (last_y ? '0 : vc + 10'd1) : vc;
            DrawX       <= hc;
            DrawY       <= vc;
            blank       <= in_span(hc, 0, H_VISIBLE) && in_span(vc, 0, V_VISIBLE);
            frame_start <= hc == '0 && vc == '0;
            line_end    <= last_x;
            // The last pixel of the frame is on the bus now; the next edge presents (0,0).
            if (line_end && DrawY == V_LAST) frame_count <= frame_count + 8'd1;
        end
    end

    // One extra stage registers the decode so hs/vs share DrawX's 1-cycle lag before the pipe delay.
    vga_sync_delay #(.DEPTH(PIPE_DELAY + 1)) u_hs_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       (hs_raw),
        .q       (hs)
    );

    vga_sync_delay #(.DEPTH(PIPE_DELAY + 1)) u_vs_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       (vs_raw),
        .q       (vs)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of full-size timing (line level), a PIPE_DELAY=0 build,
// and a shrunken-timing build for frame, wrap and mid-sync reset behaviour.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic rst_a   = 1'b0;
    logic rst_b   = 1'b0;

    always #20 vga_clk = ~vga_clk;

    logic [9:0] d_x, d_y, z_x, z_y, s_x, s_y;
    logic       d_blank, d_hs, d_vs, d_fs, d_le;
    logic       z_blank, z_hs, z_vs, z_fs, z_le;
    logic       s_blank, s_hs, s_vs, s_fs, s_le;
    logic [7:0] d_fc, z_fc, s_fc;

    vga_timing_gen u_def (
        .vga_clk(vga_clk), .reset_n(rst_a), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
        .hs(d_hs), .vs(d_vs), .frame_start(d_fs), .line_end(d_le), .frame_count(d_fc)
    );

    vga_timing_gen #(.PIPE_DELAY(0)) u_pd0 (
        .vga_clk(vga_clk), .reset_n(rst_a), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
        .hs(z_hs), .vs(z_vs), .frame_start(z_fs), .line_end(z_le), .frame_count(z_fc)
    );

    // Small raster: 15 x 8, hs raw low at x 10..12, vs raw low at y 5..6, 120 cycles per frame.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(2)
    ) u_sm (
        .vga_clk(vga_clk), .reset_n(rst_b), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .line_end(s_le), .frame_count(s_fc)
    );

    int tests = 0;
    int fails = 0;

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int p;
        int dx;
        int dy;
        bit blank;
        bit hs;
        bit hs0;
        bit fs;
        bit le;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int cur;
        int vs_first;
        int vs_low;
        int fs_cnt;
        vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{640,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{655,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{657,  657, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{658,  658, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{751,  751, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{752,  752, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{753,  753, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{754,  754, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{799,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1456, 656, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) tick;
        check("rst DrawX", d_x, 0);
        check("rst DrawY", d_y, 0);
        check("rst blank", d_blank, 0);
        check("rst frame_start", d_fs, 0);
        check("rst line_end", d_le, 0);
        check("rst frame_count", d_fc, 0);
        check("rst hs", d_hs, 1);
        check("rst vs", d_vs, 1);
        check("rst pd0 hs", z_hs, 1);
        check("rst small vs", s_vs, 1);

        rst_a = 1'b1;
        cur = -1;
        for (int i = 0; i < 15; i++) begin
            while (cur < vecs[i].p) begin
                tick;
                cur++;
            end
            check($sformatf("p%0d DrawX", cur), d_x, vecs[i].dx);
            check($sformatf("p%0d DrawY", cur), d_y, vecs[i].dy);
            check($sformatf("p%0d blank", cur), d_blank, vecs[i].blank);
            check($sformatf("p%0d hs", cur), d_hs, vecs[i].hs);
            check($sformatf("p%0d pd0 hs", cur), z_hs, vecs[i].hs0);
            check($sformatf("p%0d vs", cur), d_vs, 1);
            check($sformatf("p%0d frame_start", cur), d_fs, vecs[i].fs);
            check($sformatf("p%0d line_end", cur), d_le, vecs[i].le);
            check($sformatf("p%0d frame_count", cur), d_fc, 0);
        end

        rst_b = 1'b1;
        vs_first = -1;
        vs_low = 0;
        fs_cnt = 0;
        for (int p = 0; p <= 30807; p++) begin
            tick;
            if (p < 240) begin
                if (!s_vs && vs_first < 0) vs_first = p;
                if (!s_vs && p < 120) vs_low++;
                if (s_fs) fs_cnt++;
            end
            if (p == 0) check("sm first frame_start", s_fs, 1);
            if (p == 119) check("sm frame_count before wrap", s_fc, 0);
            if (p == 120) begin
                check("sm frame_start frame 1", s_fs, 1);
                check("sm frame_count after wrap", s_fc, 1);
            end
            if (p == 30719) check("sm frame_count 255", s_fc, 255);
            if (p == 30720) check("sm frame_count wrap to 0", s_fc, 0);
        end
        check("sm vs first low cycle", vs_first, 77);
        check("sm vs low length", vs_low, 30);
        check("sm frame_start pulses in 2 frames", fs_cnt, 2);
        check("sm pre-reset DrawX", s_x, 12);
        check("sm pre-reset DrawY", s_y, 5);
        check("sm pre-reset hs low", s_hs, 0);
        check("sm pre-reset vs low", s_vs, 0);

        rst_b = 1'b0;
        tick;
        check("mid rst hs", s_hs, 1);
        check("mid rst vs", s_vs, 1);
        check("mid rst DrawX", s_x, 0);
        check("mid rst DrawY", s_y, 0);
        check("mid rst blank", s_blank, 0);
        check("mid rst frame_start", s_fs, 0);
        check("mid rst frame_count", s_fc, 0);

        rst_b = 1'b1;
        for (int p = 0; p <= 12; p++) begin
            tick;
            if (p == 0) begin
                check("restart DrawX", s_x, 0);
                check("restart DrawY", s_y, 0);
                check("restart blank", s_blank, 1);
                check("restart frame_start", s_fs, 1);
                check("restart frame_count", s_fc, 0);
            end
            if (p == 11) check("restart hs before fall", s_hs, 1);
            if (p == 12) check("restart hs falls", s_hs, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
